// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;
endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of data grants that bypassed a waiting fetch.
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

  assign sat = (count == CNT_W'(MAX));
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data stage,
// one access in flight, data first with a starvation cap for fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  input  logic              if_flush,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  // Handshake: a request is taken in the cycle where req && ready; the requester
  // holds its request fields stable until then. ready is high only in IDLE, only
  // for the arbitration winner, and never while reset is asserted.

  state_t           state;
  owner_t           owner;
  logic             we_q;
  logic             drop;
  logic [CNT_W-1:0] lat_cnt;
  logic             starve_sat;
  logic             idle;
  logic             if_win;
  logic             dm_win;
  logic             resp;

  assign idle     = (state == IDLE) && !reset;
  assign if_win   = if_req && (!dm_req || starve_sat);
  assign dm_win   = dm_req && !if_win;
  assign if_ready = idle && if_win;
  assign dm_ready = idle && dm_win;

  arb_starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (dm_ready && if_req),
    .clr   (if_ready || !if_req),
    .sat   (starve_sat)
  );

  // A flush seen in the response cycle itself also discards the fetch data.
  assign resp      = !reset && (state == WAIT) && (lat_cnt == '0);
  assign if_rvalid = resp && (owner == OWN_IF) && !drop && !if_flush;
  assign dm_rvalid = resp && (owner == OWN_DM);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      we_q      <= 1'b0;
      drop      <= 1'b0;
      lat_cnt   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (dm_ready) begin
            mem_en    <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            owner     <= OWN_DM;
            we_q      <= dm_we;
            state     <= ISSUE;
          end else if (if_ready) begin
            mem_en   <= 1'b1;
            mem_addr <= if_addr;
            owner    <= OWN_IF;
            we_q     <= 1'b0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (owner == OWN_IF && if_flush) drop <= 1'b1;
          if (we_q) begin
            state <= IDLE;
          end else begin
            lat_cnt <= CNT_W'(MEM_LAT - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            drop  <= 1'b0;
            state <= IDLE;
          end else begin
            if (owner == OWN_IF && if_flush) drop <= 1'b1;
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed per-cycle vector table plus one timed fetch sequence for mem_port_arbiter.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_ready, if_rvalid, dm_ready, dm_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  typedef struct packed {
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        if_ready;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_ready;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  o;
    string name;
  } vec_t;

  vec_t tbl[$];
  in_t  ci;
  out_t co;
  int   checks   = 0;
  int   failures = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_flush  (if_flush),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ready  (dm_ready),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic apply(input in_t x);
    reset     = x.reset;
    if_req    = x.if_req;
    if_addr   = x.if_addr;
    if_flush  = x.if_flush;
    dm_req    = x.dm_req;
    dm_we     = x.dm_we;
    dm_addr   = x.dm_addr;
    dm_wdata  = x.dm_wdata;
    mem_rdata = x.mem_rdata;
  endtask

  task automatic push(input string nm);
    tbl.push_back('{ci, co, nm});
    ci = '0;
    co = '0;
  endtask

  task automatic hold_both();
    ci.if_req   = 1'b1;
    ci.if_addr  = 32'h30;
    ci.dm_req   = 1'b1;
    ci.dm_we    = 1'b1;
    ci.dm_addr  = 32'h40;
    ci.dm_wdata = 32'hA;
  endtask

  task automatic check_out(input string nm, input out_t e);
    out_t a;
    a = {if_ready, if_rvalid, if_rdata, dm_ready, dm_rvalid, dm_rdata,
         mem_en, mem_we, mem_addr, mem_wdata};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, a, e);
    end
  endtask

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // vector table: one record per cycle, cycle 0 = first cycle after reset
  task automatic build_table();
    ci = '0;
    co = '0;
    for (int r = 0; r < 2; r++) begin
      ci.reset     = 1'b1;
      ci.if_req    = 1'($urandom_range(0, 1));
      ci.if_addr   = $urandom;
      ci.if_flush  = 1'($urandom_range(0, 1));
      ci.dm_req    = 1'($urandom_range(0, 1));
      ci.dm_we     = 1'($urandom_range(0, 1));
      ci.dm_addr   = $urandom;
      ci.dm_wdata  = $urandom;
      ci.mem_rdata = $urandom;
      push($sformatf("reset_%0d", r));
    end
    // lone fetch
    ci.if_req = 1; ci.if_addr = 32'h10; co.if_ready = 1;    push("fetch_c0_ready");
    co.mem_en = 1; co.mem_addr = 32'h10;                     push("fetch_c1_issue");
    ci.mem_rdata = 32'hDEADBEEF;                             push("fetch_c2_wait");
    ci.mem_rdata = 32'hE2803006; co.if_rvalid = 1; co.if_rdata = 32'hE2803006;
    push("fetch_c3_rvalid");
    ci.if_req = 1; ci.if_addr = 32'h20; co.if_ready = 1;    push("fetch_c4_ready_again");
    co.mem_en = 1; co.mem_addr = 32'h20;                     push("fetch2_issue");
    push("fetch2_wait");
    ci.mem_rdata = 32'h11111111; co.if_rvalid = 1; co.if_rdata = 32'h11111111;
    push("fetch2_rvalid_dm_rdata_zero");
    // conflict: store wins, fetch follows once the port is idle
    ci.if_req = 1; ci.if_addr = 32'h14;
    ci.dm_req = 1; ci.dm_we = 1; ci.dm_addr = 32'h0B; ci.dm_wdata = 32'h6;
    co.dm_ready = 1;                                         push("conf_c0_dm_wins");
    ci.if_req = 1; ci.if_addr = 32'h14;
    co.mem_en = 1; co.mem_we = 1; co.mem_addr = 32'h0B; co.mem_wdata = 32'h6;
    push("conf_c1_store_issue");
    ci.if_req = 1; ci.if_addr = 32'h14; co.if_ready = 1;    push("conf_c2_if_ready");
    ci.mem_rdata = 32'h99; co.mem_en = 1; co.mem_addr = 32'h14;
    push("conf_c3_fetch_issue");
    push("conf_c4_wait");
    ci.mem_rdata = 32'hE3A01000; co.if_rvalid = 1; co.if_rdata = 32'hE3A01000;
    push("conf_c5_rvalid");
    // starvation: DM stores at 0,2,4,6; IF forced at 8
    for (int g = 0; g < 4; g++) begin
      hold_both(); co.dm_ready = 1;                          push($sformatf("starve_dm_grant_%0d", g));
      hold_both();
      co.mem_en = 1; co.mem_we = 1; co.mem_addr = 32'h40; co.mem_wdata = 32'hA;
      push($sformatf("starve_dm_issue_%0d", g));
    end
    hold_both(); co.if_ready = 1;                            push("starve_c8_if_forced");
    hold_both(); ci.if_addr = 32'h34;
    co.mem_en = 1; co.mem_addr = 32'h30;                     push("starve_c9_if_issue");
    hold_both(); ci.if_addr = 32'h34;                        push("starve_c10_wait");
    hold_both(); ci.if_addr = 32'h34; ci.mem_rdata = 32'hE1A00000;
    co.if_rvalid = 1; co.if_rdata = 32'hE1A00000;            push("starve_c11_rvalid");
    // the IF read occupies cycles 8..11, so DM regains the port at 12
    hold_both(); ci.if_addr = 32'h34; co.dm_ready = 1;       push("starve_c12_dm_again");
    ci.if_req = 1; ci.if_addr = 32'h34;
    co.mem_en = 1; co.mem_we = 1; co.mem_addr = 32'h40; co.mem_wdata = 32'hA;
    push("starve_c13_issue");
    ci.if_req = 1; ci.if_addr = 32'h34; co.if_ready = 1;    push("starve_c14_if_ready");
    co.mem_en = 1; co.mem_addr = 32'h34;                     push("starve_c15_issue");
    push("starve_c16_wait");
    ci.mem_rdata = 32'hE0811002; co.if_rvalid = 1; co.if_rdata = 32'hE0811002;
    push("starve_c17_rvalid");
    // flush of an outstanding fetch, then a normal load
    ci.if_req = 1; ci.if_addr = 32'h50; co.if_ready = 1;    push("flush_c0_ready");
    co.mem_en = 1; co.mem_addr = 32'h50;                     push("flush_c1_issue");
    ci.if_flush = 1;                                         push("flush_c2_flush");
    ci.mem_rdata = 32'h12345678;                             push("flush_c3_suppressed");
    ci.dm_req = 1; ci.dm_addr = 32'h80; co.dm_ready = 1;    push("flush_c4_idle_ldr");
    co.mem_en = 1; co.mem_addr = 32'h80;                     push("flush_ldr_issue");
    ci.if_flush = 1;                                         push("flush_ldr_wait_flush_ignored");
    ci.mem_rdata = 32'hCAFEF00D; co.dm_rvalid = 1; co.dm_rdata = 32'hCAFEF00D;
    push("flush_ldr_rvalid");
    ci.if_req = 1; ci.if_addr = 32'h58; ci.if_flush = 1; co.if_ready = 1;
    push("flush_idle_no_effect");
    co.mem_en = 1; co.mem_addr = 32'h58;                     push("flush_idle_issue");
    push("flush_idle_wait");
    ci.mem_rdata = 32'h0A000001; co.if_rvalid = 1; co.if_rdata = 32'h0A000001;
    push("flush_idle_rvalid");
    // reset in the middle of a load
    ci.dm_req = 1; ci.dm_addr = 32'h90; co.dm_ready = 1;    push("rst_c0_ldr_ready");
    co.mem_en = 1; co.mem_addr = 32'h90;                     push("rst_c1_issue");
    ci.reset = 1; ci.mem_rdata = 32'h33;                     push("rst_c2_reset");
    ci.mem_rdata = 32'h55555555;                             push("rst_c3_abandoned");
    ci.mem_rdata = 32'h66;                                   push("rst_c4_quiet");
    ci.dm_req = 1; ci.dm_addr = 32'h94; co.dm_ready = 1;    push("rst_after_ready");
    co.mem_en = 1; co.mem_addr = 32'h94;                     push("rst_after_issue");
    push("rst_after_wait");
    ci.mem_rdata = 32'h77; co.dm_rvalid = 1; co.dm_rdata = 32'h77;
    push("rst_after_rvalid");
  endtask

  // hand-written sequence: fetch latency measured against a bounded wait
  task automatic timed_fetch(input logic [31:0] a, input logic [31:0] d);
    int  n;
    bit  seen;
    in_t x;
    x = '0;
    x.if_req = 1'b1;
    x.if_addr = a;
    x.mem_rdata = d;
    apply(x);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (if_ready) seen = 1;
      @(posedge clk); #1;
    end
    check_val("timed_accept", 32'(seen), 32'd1);
    x.if_req = 1'b0;
    apply(x);
    seen = 0;
    n = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      n++;
      @(negedge clk);
      if (if_rvalid) seen = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    // accepted at N, rvalid at N+1+MEM_LAT
    check_val("timed_latency", 32'(n), seen ? 32'd3 : 32'hFFFFFFFF);
    check_val("timed_rdata", if_rdata, d);
    @(posedge clk); #1;
  endtask

  initial begin
    ci = '0;
    ci.reset = 1'b1;
    apply(ci);
    build_table();
    @(posedge clk); #1;
    for (int v = 0; v < tbl.size(); v++) begin
      apply(tbl[v].i);
      @(negedge clk);
      check_out(tbl[v].name, tbl[v].o);
      @(posedge clk); #1;
    end
    timed_fetch(32'h200, 32'hE59F1004);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
